collision_detect: RTL and testbench

- Upstream stage of `ball_movement`; feeds its `paddle_collision` and `wall_collision` inputs.
- On each frame tick, compares ball position and direction against both paddles, the top and bottom walls, and the left and right goal edges.
- Issues registered one-cycle event pulses, applies per-type hold-off so one overlap never double-reports, and runs a serve/play state machine with a rally counter.

---
 rtl/collision_detect.sv | 192 +++++++++++++++++++
 tb/tb_collision_detect.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/collision_detect.sv
// collision_detect: per-frame ball collision and scoring detector feeding ball_movement.
// On each frame tick in PLAY it checks the ball against both paddles, the top/bottom
// walls and the goal edges, and emits registered one-cycle event pulses. Paddle and
// wall events each have a hold-off counter so one overlap is not reported repeatedly.
// A serve/play FSM gates evaluation and a saturating rally counter tracks paddle hits.
// Optional feature macro: COLLIDE_SCORE_EN (goal detection and the WAIT/serve flow).
// Without it the block comes out of reset already playing and never scores.
module collision_detect #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_W  = 8,
    parameter int PADDLE_H  = 64,
    parameter int PADDLE_LX = 16,
    parameter int PADDLE_RX = 616,
    parameter int COOLDOWN  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       serve,
    input  logic [9:0] bx,
    input  logic [8:0] by,
    input  logic       bx_dir,
    input  logic       by_dir,
    input  logic [8:0] pl_y,
    input  logic [8:0] pr_y,
    output logic       paddle_collision,
    output logic       paddle_side,
    output logic       wall_collision,
    output logic       score_left,
    output logic       score_right,
    output logic       playing,
    output logic [7:0] rally_count
);

    typedef enum logic {
        WAIT = 1'b0,
        PLAY = 1'b1
    } state_t;

`ifdef COLLIDE_SCORE_EN
    localparam state_t RESET_STATE = WAIT;
`else
    localparam state_t RESET_STATE = PLAY;
`endif

    // The event tick itself is the first suppressed tick, so the counter is loaded
    // with COOLDOWN-1: the same event type is masked on the following COOLDOWN-1 ticks
    // and can fire again on the COOLDOWN-th tick after the event.
    localparam int CNT_W = $clog2(COOLDOWN + 1);
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN - 1);

    // All geometry is compared one bit wider than the inputs so sums cannot wrap.
    logic [10:0] bx_w, bx_end;
    logic [9:0]  by_w, by_end, pl_top, pl_bot, pr_top, pr_bot;
    logic        left_hit, right_hit, wall_hit;

    assign bx_w   = {1'b0, bx};
    assign bx_end = bx_w + 11'(BALL_SIZE);
    assign by_w   = {1'b0, by};
    assign by_end = by_w + 10'(BALL_SIZE);
    assign pl_top = {1'b0, pl_y};
    assign pl_bot = pl_top + 10'(PADDLE_H);
    assign pr_top = {1'b0, pr_y};
    assign pr_bot = pr_top + 10'(PADDLE_H);

    assign left_hit  = !bx_dir && (bx_w <= 11'(PADDLE_LX + PADDLE_W)) && (bx_end > 11'(PADDLE_LX))
                       && (by_end > pl_top) && (by_w < pl_bot);
    assign right_hit = bx_dir && (bx_end >= 11'(PADDLE_RX)) && (bx_w < 11'(PADDLE_RX + PADDLE_W))
                       && (by_end > pr_top) && (by_w < pr_bot);
    assign wall_hit  = (!by_dir && (by == 9'd0)) || (by_dir && (by_end >= 10'(SCREEN_H)));

`ifdef COLLIDE_SCORE_EN
    logic exit_left, exit_right;
    assign exit_left  = !bx_dir && (bx == 10'd0);
    assign exit_right = bx_dir && (bx_end >= 11'(SCREEN_W));
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cd_pad_reg, cd_pad_next, cd_wall_reg, cd_wall_next;
    logic             paddle_collision_reg, paddle_collision_next;
    logic             paddle_side_reg, paddle_side_next;
    logic             wall_collision_reg, wall_collision_next;
    logic             score_left_reg, score_left_next;
    logic             score_right_reg, score_right_next;
    logic [7:0]       rally_reg, rally_next;
    logic             clear, eval, pad_ev, wall_ev;

    // Next-state, cooldown, rally and pulse logic; evaluation only on PLAY ticks.
    always_comb begin
        state_next            = state_reg;
        cd_pad_next           = cd_pad_reg;
        cd_wall_next          = cd_wall_reg;
        paddle_collision_next = 1'b0;
        paddle_side_next      = paddle_side_reg;
        wall_collision_next   = 1'b0;
        score_left_next       = 1'b0;
        score_right_next      = 1'b0;
        rally_next            = rally_reg;
        clear                 = 1'b0;
        eval                  = 1'b0;

        case (state_reg)
            WAIT: begin
                // A tick arriving together with serve is dropped.
                if (serve) begin
                    state_next = PLAY;
                    clear      = 1'b1;
                end
            end
            PLAY: begin
`ifdef COLLIDE_SCORE_EN
                eval = tick;
`else
                if (serve) begin
                    clear = 1'b1;
                end else begin
                    eval = tick;
                end
`endif
            end
            default: state_next = RESET_STATE;
        endcase

        pad_ev  = eval && (left_hit || right_hit) && (cd_pad_reg == '0);
        wall_ev = eval && wall_hit && (cd_wall_reg == '0);

        if (clear) begin
            rally_next   = 8'd0;
            cd_pad_next  = '0;
            cd_wall_next = '0;
        end

        if (eval) begin
            cd_pad_next  = pad_ev ? CD_LOAD
                         : ((cd_pad_reg != '0) ? cd_pad_reg - CNT_W'(1) : '0);
            cd_wall_next = wall_ev ? CD_LOAD
                         : ((cd_wall_reg != '0) ? cd_wall_reg - CNT_W'(1) : '0);
            paddle_collision_next = pad_ev;
            wall_collision_next   = wall_ev;
            if (pad_ev) begin
                paddle_side_next = right_hit;
                if (rally_reg != 8'hFF) begin
                    rally_next = rally_reg + 8'd1;
                end
            end
`ifdef COLLIDE_SCORE_EN
            // A paddle overlap on the same tick wins over a goal exit.
            score_left_next  = exit_right && !(left_hit || right_hit);
            score_right_next = exit_left && !(left_hit || right_hit);
            if (score_left_next || score_right_next) begin
                state_next = WAIT;
            end
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= RESET_STATE;
            cd_pad_reg           <= '0;
            cd_wall_reg          <= '0;
            paddle_collision_reg <= 1'b0;
            paddle_side_reg      <= 1'b0;
            wall_collision_reg   <= 1'b0;
            score_left_reg       <= 1'b0;
            score_right_reg      <= 1'b0;
            rally_reg            <= 8'd0;
        end else begin
            state_reg            <= state_next;
            cd_pad_reg           <= cd_pad_next;
            cd_wall_reg          <= cd_wall_next;
            paddle_collision_reg <= paddle_collision_next;
            paddle_side_reg      <= paddle_side_next;
            wall_collision_reg   <= wall_collision_next;
            score_left_reg       <= score_left_next;
            score_right_reg      <= score_right_next;
            rally_reg            <= rally_next;
        end
    end

    assign paddle_collision = paddle_collision_reg;
    assign paddle_side      = paddle_side_reg;
    assign wall_collision   = wall_collision_reg;
    assign score_left       = score_left_reg;
    assign score_right      = score_right_reg;
    assign playing          = (state_reg == PLAY);
    assign rally_count      = rally_reg;

endmodule

// File: tb/tb_collision_detect.sv
// Scoreboard bench for collision_detect: each stimulus cycle queues the output set
// expected in the following cycle; a negedge monitor pops and compares.
// Handles both builds (COLLIDE_SCORE_EN defined or not).
module tb_collision_detect;

`ifdef COLLIDE_SCORE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif
    // playing after reset / after a score
    localparam bit P0 = !SC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] bx = 10'd320;
    logic [8:0] by = 9'd200;
    logic       bx_dir = 1'b0;
    logic       by_dir = 1'b0;
    logic [8:0] pl_y = 9'd0;
    logic [8:0] pr_y = 9'd0;
    logic       paddle_collision, paddle_side, wall_collision;
    logic       score_left, score_right, playing;
    logic [7:0] rally_count;

    collision_detect dut (
        .clk              (clk),
        .reset            (reset),
        .tick             (tick),
        .serve            (serve),
        .bx               (bx),
        .by               (by),
        .bx_dir           (bx_dir),
        .by_dir           (by_dir),
        .pl_y             (pl_y),
        .pr_y             (pr_y),
        .paddle_collision (paddle_collision),
        .paddle_side      (paddle_side),
        .wall_collision   (wall_collision),
        .score_left       (score_left),
        .score_right      (score_right),
        .playing          (playing),
        .rally_count      (rally_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [13:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc_count = 0;
    int   checks = 0;
    int   passed = 0;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    // Monitor: compare every queued expectation due at or before this cycle.
    always @(negedge clk) begin
        logic [13:0] got;
        exp_t e;
        got = {paddle_collision, paddle_side, wall_collision, score_left, score_right,
               playing, rally_count};
        while (sb.size() > 0 && sb[0].cyc <= cyc_count) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc == cyc_count && got === e.exp) begin
                passed++;
            end else begin
                $display("FAIL %s: got pc=%b side=%b wc=%b sl=%b sr=%b play=%b rally=%0d, want pc=%b side=%b wc=%b sl=%b sr=%b play=%b rally=%0d (cyc %0d/%0d)",
                         e.name, got[13], got[12], got[11], got[10], got[9], got[8], got[7:0],
                         e.exp[13], e.exp[12], e.exp[11], e.exp[10], e.exp[9], e.exp[8],
                         e.exp[7:0], cyc_count, e.cyc);
            end
            $display("check %-18s pc=%b side=%b wc=%b sl=%b sr=%b play=%b rally=%0d",
                     e.name, got[13], got[12], got[11], got[10], got[9], got[8], got[7:0]);
        end
    end

    task automatic pos(input logic [9:0] x, input logic [8:0] y, input logic xd, input logic yd,
                       input logic [8:0] ly, input logic [8:0] ry);
        bx = x; by = y; bx_dir = xd; by_dir = yd; pl_y = ly; pr_y = ry;
    endtask

    // One clock of stimulus plus the outputs expected in the next cycle.
    task automatic step(input logic r, input logic t, input logic s,
                        input logic pc, input logic side, input logic wc,
                        input logic sl, input logic sr, input logic play,
                        input logic [7:0] rally, input string name);
        exp_t e;
        reset = r; tick = t; serve = s;
        e.cyc  = cyc_count + 1;
        e.exp  = {pc, side, wc, sl, sr, play, rally};
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0; tick = 1'b0; serve = 1'b0;
    endtask

    // Neutral ticks that only let cooldown counters run down.
    task automatic drain(input logic side, input logic [7:0] rally);
        pos(10'd320, 9'd200, 1'b0, 1'b0, 9'd0, 9'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, side, 0, 0, 0, 1, rally, "drain");
    endtask

    initial begin
        @(posedge clk);
        #1;
        //    r  t  s  pc sd wc sl sr play rally
        step(1, 0, 0, 0, 0, 0, 0, 0, P0, 8'd0, "reset");
        step(1, 1, 0, 0, 0, 0, 0, 0, P0, 8'd0, "reset_hold");
        step(0, 1, 0, 0, 0, 0, 0, 0, P0, 8'd0, "idle_tick");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, 8'd0, "serve_with_tick");

        // left paddle hit, then cooldown
        pos(10'd20, 9'd100, 1'b0, 1'b0, 9'd80, 9'd0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 1, 8'd1, "left_hit");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'd1, "no_tick");
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 8'd1, "cooldown_2");
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 8'd1, "cooldown_3");
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 8'd1, "cooldown_4");
        step(0, 1, 0, 1, 0, 0, 0, 0, 1, 8'd2, "cooldown_expired");
        drain(0, 8'd2);

        // bottom wall, then same position moving up
        pos(10'd320, 9'd472, 1'b0, 1'b1, 9'd80, 9'd0);
        step(0, 1, 0, 0, 0, 1, 0, 0, 1, 8'd2, "wall_bottom");
        pos(10'd320, 9'd472, 1'b0, 1'b0, 9'd80, 9'd0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 8'd2, "wall_wrong_dir");
        drain(0, 8'd2);

        // right paddle and top wall together, no score
        pos(10'd612, 9'd0, 1'b1, 1'b0, 9'd80, 9'd0);
        step(0, 1, 0, 1, 1, 1, 0, 0, 1, 8'd3, "corner");
        drain(1, 8'd3);

        pos(10'd320, 9'd0, 1'b0, 1'b0, 9'd80, 9'd0);
        step(0, 1, 0, 0, 1, 1, 0, 0, 1, 8'd3, "wall_top");
        drain(1, 8'd3);

        // left goal exit
        pos(10'd0, 9'd100, 1'b0, 1'b0, 9'd300, 9'd0);
        step(0, 1, 0, 0, 1, 0, 0, SC, P0, 8'd3, "score_right");
        step(0, 1, 0, 0, 1, 0, 0, 0, P0, 8'd3, "after_score");
        step(0, 0, 1, 0, 1, 0, 0, 0, 1, 8'd0, "reserve");

        // right goal exit
        pos(10'd632, 9'd200, 1'b1, 1'b0, 9'd80, 9'd0);
        step(0, 1, 0, 0, 1, 0, SC, 0, P0, 8'd0, "score_left");
        step(0, 0, 1, 0, 1, 0, 0, 0, 1, 8'd0, "reserve2");

        // reset in the middle of an active paddle cooldown
        pos(10'd612, 9'd200, 1'b1, 1'b0, 9'd80, 9'd180);
        step(0, 1, 0, 1, 1, 0, 0, 0, 1, 8'd1, "right_hit");
        step(1, 1, 0, 0, 0, 0, 0, 0, P0, 8'd0, "reset_mid_play");
        step(0, 0, 1, 0, 0, 0, 0, 0, 1, 8'd0, "serve_after_reset");
        step(0, 1, 0, 1, 1, 0, 0, 0, 1, 8'd1, "post_reset_hit");
        step(0, 0, 0, 0, 1, 0, 0, 0, 1, 8'd1, "pulse_ends");

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL queue_drain: %0d entries left, want 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
